// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle sequencer for the E-stage multiply/divide unit.
// Owns architectural HI/LO. A mult/div result is computed on the issue edge
// and held in shadow registers. It is committed only after the fixed
// latency, so HI/LO never expose a partial result. A CP0 request in the
// issue cycle suppresses the issue completely. A request that arrives later
// cannot abort an operation that is already in flight.

module mdu_seq #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Operation encodings presented by the E-stage decoder.
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Sequencer states.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // The down-counter must hold the longer of the two latencies.
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [0:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   shadow_hi;
  logic [31:0]   shadow_lo;
  // Cleared for divide-by-zero, so that HI/LO keep their values at completion.
  logic          shadow_commit;

  // Issue decode.
  logic accept;
  logic is_mul;
  logic is_div;
  logic is_signed;

  // Arithmetic datapath signals.
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_commit;

  assign accept    = start && !Req && (state == IDLE) &&
                     (op != OP_NONE) && (op != 3'd7);
  assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);

  // Both products are formed at full 64-bit width from explicitly extended
  // operands, so the signedness of the result never depends on context.
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // The signed divide runs on operand magnitudes and then restores the signs.
  // This handles 0x80000000 / -1 without overflow: the magnitude quotient
  // 0x80000000 keeps its sign, and the remainder is zero.
  // The divisor is forced to 1 when b==0, so the divider never sees zero.
  // The commit flag discards that quotient at completion.
  assign dvd_mag  = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign dvs_mag  = (is_signed && b[31]) ? (32'd0 - b) : b;
  assign dvs_safe = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign q_mag    = dvd_mag / dvs_safe;
  assign r_mag    = dvd_mag % dvs_safe;
  assign q_neg    = is_signed && (a[31] ^ b[31]);
  assign r_neg    = is_signed && a[31];

  // Select the result that this issue will commit at completion.
  always_comb begin
    // NOTE: every output gets a default first, so that no path infers a latch.
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    res_commit = 1'b1;
    if (is_mul) begin
      res_hi = is_signed ? prod_s[63:32] : prod_u[63:32];
      res_lo = is_signed ? prod_s[31:0]  : prod_u[31:0];
    end else if (is_div) begin
      res_hi     = r_neg ? (32'd0 - r_mag) : r_mag;
      res_lo     = q_neg ? (32'd0 - q_mag) : q_mag;
      res_commit = (b != 32'd0);
    end
  end

  // Sequencer FSM and latency counter. The result is captured into the
  // shadow registers on the issue edge.
  // NOTE: the asynchronous reset clears every register, shadows included,
  // so a discarded result can never resurface after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // flops update together at the edge.
      state         <= IDLE;
      count         <= '0;
      shadow_hi     <= 32'd0;
      shadow_lo     <= 32'd0;
      shadow_commit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && (is_mul || is_div)) begin
            shadow_hi     <= res_hi;
            shadow_lo     <= res_lo;
            shadow_commit <= res_commit;
            count         <= is_mul ? MUL_LOAD : DIV_LOAD;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (count == ONE) begin
            count <= '0;
            state <= IDLE;
          end else begin
            count <= count - ONE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Architectural HI/LO. mthi/mtlo write directly, and a completing
  // multiply/divide copies in its shadow result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if ((state == BUSY) && (count == ONE)) begin
      if (shadow_commit) begin
        hi <= shadow_hi;
        lo <= shadow_lo;
      end
    end else if (accept && (op == OP_MTHI)) begin
      hi <= a;
    end else if (accept && (op == OP_MTLO)) begin
      lo <= a;
    end
  end

  // busy decodes the state, so the asynchronous reset clears it at once.
  assign busy = (state == BUSY);

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Sequencer for the E-stage multiply/divide resource. Accepts one MDU operation per issue and models the fixed multi-cycle latency with an FSM and down-counter.
- Owns the architectural HI/LO registers and presents the busy signal that the stall unit combines with start.
- Honours the CP0 interrupt/exception request so a victim instruction in E never commits to HI/LO.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- Req  input  1  CP0 exception/interrupt request; masks start in the same cycle
- start  input  1  issue strobe from the E-stage decoder
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- busy  output  1  operation in flight
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (asynchronous): state=IDLE, count=0, busy=0, hi=0, lo=0, shadow registers=0.
- Accept condition: start & !Req & state==IDLE & op in 1..6.
  - start while busy is ignored; the stall unit guarantees this does not happen.
  - op 0 or 7 with start is ignored.
  - Req=1 masks start entirely, and nothing changes.
- mthi/mtlo: on the accept edge, hi<=a or lo<=a respectively. No busy. State stays IDLE.
- mult/multu/div/divu issue:
  - On the accept edge, compute the result from a and b and latch it into shadow_hi/shadow_lo.
  - Load count with MUL_CYCLES or DIV_CYCLES, go to BUSY, set busy=1.
  - If the accept edge is k, busy=1 during cycles k+1..k+LAT.
- BUSY state:
  - count decrements every edge.
  - On the edge where count==1: hi<=shadow_hi, lo<=shadow_lo, busy<=0, state<=IDLE.
  - New values are visible in the first cycle that busy=0.
  - hi/lo keep their old values throughout BUSY, so an mfhi can never read a partial result.
- Req during BUSY does not abort. The in-flight op belongs to an older instruction that has already left E, so it completes normally.
- Back-to-back issue: start on the same cycle busy drops (IDLE reached) is accepted. Zero dead cycles.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - multu: unsigned, same split.
  - div: signed, quotient truncated toward zero into lo, remainder (sign of dividend) into hi.
  - divu: unsigned; lo=quotient, hi=remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
  - b==0 for div/divu: the op still runs full latency, and hi/lo are left unchanged at completion.
- Reset mid-operation: immediate return to IDLE; busy=0, hi=lo=0; the pending result is discarded.

Test Plan:
- After reset: a=7, b=6, op=mult, start=1 for 1 cycle -> busy=1 for exactly 5 cycles; hi=0 and lo=0 during busy; then hi=0, lo=42 with busy=0.
- op=div with a=0xFFFFFFF9 (-7), b=2 -> busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with divu: lo=0x7FFFFFFC, hi=1.
- Prior state hi=0x11, lo=0x22; issue multu a=0xFFFFFFFF, b=0xFFFFFFFF with Req=1 in the start cycle -> busy stays 0; hi=0x11, lo=0x22 unchanged.
- Start mult, then pulse Req in cycle 2 of busy -> op completes on schedule with the correct product. In the cycle busy falls, issue mtlo a=0x5 -> lo=0x5 at the next edge.
- div with b=0 and prior hi=0xA, lo=0xB -> busy 10 cycles; afterwards hi=0xA, lo=0xB. Also check 0x80000000/-1 -> lo=0x80000000, hi=0.
- Assert reset asynchronously in cycle 3 of a div -> busy, hi and lo go to 0 without waiting for a clock edge. Next mthi a=0x1234 -> hi=0x1234, and no stale result appears later.
